// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline-side hazard inputs and the stall/flush
// controls, debug state and performance counters returned to the pipeline.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
) ();

   // Pipeline observations
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             ex_memread;
   logic [4:0]       ex_rt;
   logic             mem_pcsrc;
   logic             ext_hold;

   // Pipeline controls and debug/perf outputs
   logic             pc_stall;
   logic             ifid_stall;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic             hold_err;

   // Pipeline side: supplies hazard information, consumes controls
   modport master (
      output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, mem_pcsrc, ext_hold,
      input  pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush,
      input  state_o, stall_cnt, flush_cnt, hold_err
   );

   // Hazard controller side
   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, mem_pcsrc, ext_hold,
      output pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush,
      output state_o, stall_cnt, flush_cnt, hold_err
   );

endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: detects load-use hazards, taken branches resolved in
// MEM and debug hold requests, and produces registered stall/flush controls
// for the IF/ID, ID/EX and EX/MEM registers. Controls change on posedge so
// they are stable when the pipeline registers capture on negedge.
module hazard_ctrl #(
   parameter int CNT_W    = 16,
   parameter int MAX_HOLD = 255
) (
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave bus
);

   localparam int TMR_W = $clog2(MAX_HOLD + 1);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [TMR_W-1:0] HOLD_LIM = TMR_W'(MAX_HOLD);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_BR_FLUSH = 2'd2,
      ST_HOLD     = 2'd3
   } state_e;

   // Control vector order: {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush}
   function automatic logic [4:0] decode_ctrl(input state_e s);
      logic [4:0] c;
      case (s)
         ST_RUN:      c = 5'b00000;
         ST_LU_STALL: c = 5'b11010;
         ST_BR_FLUSH: c = 5'b00111;
         ST_HOLD:     c = 5'b11010;
         default:     c = 5'b00000;
      endcase
      return c;
   endfunction

   state_e           state_q,     state_d;
   logic [4:0]       ctrl_q,      ctrl_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [TMR_W-1:0] hold_tmr_q,  hold_tmr_d;
   logic             hold_err_q,  hold_err_d;
   logic             lu_s;
   logic             stalling_s;

   // Load-use hazard: load in EX writes a register the ID instruction reads ($zero excluded)
   always_comb begin
      lu_s = 1'b0;
      if (bus.ex_memread && (bus.ex_rt != 5'd0)) begin
         lu_s = (bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt));
      end else begin
         lu_s = 1'b0;
      end
   end

   // Next state: branch flush beats hold beats load-use; a flush never re-triggers on its own branch
   always_comb begin
      state_d = ST_RUN;
      case (state_q)
         ST_BR_FLUSH: begin
            if (bus.ext_hold) begin
               state_d = ST_HOLD;
            end else if (lu_s) begin
               state_d = ST_LU_STALL;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN, ST_LU_STALL, ST_HOLD: begin
            if (bus.mem_pcsrc) begin
               state_d = ST_BR_FLUSH;
            end else if (bus.ext_hold) begin
               state_d = ST_HOLD;
            end else if (lu_s) begin
               state_d = ST_LU_STALL;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Controls are decoded from the upcoming state so they leave the flop together with it
   always_comb begin
      ctrl_d = decode_ctrl(state_d);
   end

   // Performance counters: stall cycles counted per cycle spent stalled, flushes per entry
   always_comb begin
      stalling_s  = (state_q == ST_LU_STALL) || (state_q == ST_HOLD);
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stalling_s && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if ((state_d == ST_BR_FLUSH) && (state_q != ST_BR_FLUSH) && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Hold timer tracks consecutive HOLD cycles; the error flag is sticky once the limit is reached
   always_comb begin
      hold_tmr_d = '0;
      hold_err_d = hold_err_q;
      if (state_d == ST_HOLD) begin
         if (hold_tmr_q != HOLD_LIM) begin
            hold_tmr_d = hold_tmr_q + TMR_ONE;
         end else begin
            hold_tmr_d = hold_tmr_q;
         end
      end else begin
         hold_tmr_d = '0;
      end
      if (hold_tmr_d == HOLD_LIM) begin
         hold_err_d = 1'b1;
      end else begin
         hold_err_d = hold_err_q;
      end
   end

   // State, control and counter registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         ctrl_q      <= 5'b00000;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         hold_tmr_q  <= '0;
         hold_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctrl_q      <= ctrl_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         hold_tmr_q  <= hold_tmr_d;
         hold_err_q  <= hold_err_d;
      end
   end

   assign bus.pc_stall    = ctrl_q[4];
   assign bus.ifid_stall  = ctrl_q[3];
   assign bus.ifid_flush  = ctrl_q[2];
   assign bus.idex_flush  = ctrl_q[1];
   assign bus.exmem_flush = ctrl_q[0];
   assign bus.state_o     = state_q;
   assign bus.stall_cnt   = stall_cnt_q;
   assign bus.flush_cnt   = flush_cnt_q;
   assign bus.hold_err    = hold_err_q;

endmodule
